// File: rtl/bias_pkg.sv
// Shared types and defaults for the run-time bias memory loader.
package bias_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_H = 2'd1,
        LOAD_O = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_H_NODE_NUMBER = 20;
    localparam int DEF_O_NODE_NUMBER = 10;
    localparam int DEF_DATA_WIDTH    = 8;

    // Index must address the larger of the two banks; never narrower than 1 bit.
    function automatic int idx_width(input int h_nodes, input int o_nodes);
        int m;
        m = (h_nodes > o_nodes) ? h_nodes : o_nodes;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bias_bank.sv
// N x DATA_WIDTH register bank, written one entry at a time, read as one flat vector.
module bias_bank
    import bias_pkg::*;
#(
    parameter int N          = DEF_H_NODE_NUMBER,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [N*DATA_WIDTH-1:0] data
);

    // Entry i lives at [i*DATA_WIDTH +: DATA_WIDTH], node 0 in the low byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (we) begin
            for (int i = 0; i < N; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    data[i*DATA_WIDTH +: DATA_WIDTH] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/bias_mem_loader.sv
// Streams bias bytes into a hidden-layer bank and then an output-layer bank,
// so the network biases can be reprogrammed at run time.
module bias_mem_loader
    import bias_pkg::*;
#(
    parameter int H_NODE_NUMBER = DEF_H_NODE_NUMBER,
    parameter int O_NODE_NUMBER = DEF_O_NODE_NUMBER,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [H_NODE_NUMBER*DATA_WIDTH-1:0] h_bias,
    output logic [O_NODE_NUMBER*DATA_WIDTH-1:0] o_bias,
    output logic                                busy,
    output logic                                done
);

    localparam int IDX_W = idx_width(H_NODE_NUMBER, O_NODE_NUMBER);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             we_h, we_o;
    logic             xfer;

    // Handshake: a byte moves on a rising edge with in_valid && in_ready.
    // in_ready is a flop decoded from the next state only (high in LOAD_H/LOAD_O),
    // so there is no combinational path from in_valid back to in_ready.
    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            in_ready <= (state_nx == LOAD_H) || (state_nx == LOAD_O);
            busy     <= (state_nx == LOAD_H) || (state_nx == LOAD_O);
            done     <= (state_nx == DONE);
        end
    end

    // Abort outranks both start and a coinciding transfer in every state.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        we_h     = 1'b0;
        we_o     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (start) begin
                    idx_nx   = '0;
                    state_nx = LOAD_H;
                end
            end
            LOAD_H: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (xfer) begin
                    we_h = 1'b1;
                    if (idx == IDX_W'(H_NODE_NUMBER - 1)) begin
                        idx_nx   = '0;
                        state_nx = LOAD_O;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            LOAD_O: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (xfer) begin
                    we_o = 1'b1;
                    if (idx == IDX_W'(O_NODE_NUMBER - 1)) begin
                        idx_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    bias_bank #(
        .N          (H_NODE_NUMBER),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (IDX_W)
    ) u_h_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (we_h),
        .waddr (idx),
        .wdata (in_data),
        .data  (h_bias)
    );

    bias_bank #(
        .N          (O_NODE_NUMBER),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (IDX_W)
    ) u_o_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (we_o),
        .waddr (idx),
        .wdata (in_data),
        .data  (o_bias)
    );

endmodule

// File: doc/bias_mem_loader.md
Name: bias_mem_loader

Overview:
Write-side counterpart to the hidden/output bias memories. Accepts bias bytes one at a time over a valid/ready stream and fills a hidden-layer bank of H_NODE_NUMBER entries, then an output-layer bank of O_NODE_NUMBER entries. Presents both banks as flat concatenated vectors with node 0 in the least-significant byte, so the banks drop in wherever the hidden/output bias vectors are consumed. Lets the network be reprogrammed at run time instead of only from file at elaboration.

Parameters:
- H_NODE_NUMBER, 20, number of hidden-layer bias entries
- O_NODE_NUMBER, 10, number of output-layer bias entries
- DATA_WIDTH, 8, bits per bias entry

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a load sequence; sampled only in IDLE or DONE
- abort  in  1  abandon the current load; return to IDLE
- in_data  in  DATA_WIDTH  bias byte, two's complement, passed through unchanged
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts in_data this cycle
- h_bias  out  H_NODE_NUMBER*DATA_WIDTH  hidden bank; node i at [i*DATA_WIDTH +: DATA_WIDTH]
- o_bias  out  O_NODE_NUMBER*DATA_WIDTH  output bank; node i at [i*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high in LOAD_H or LOAD_O
- done  out  1  high in DONE; all entries of both banks written by the last sequence

Behaviour:
- Reset: state IDLE; all h_bias and o_bias bytes 0; index 0; in_ready 0; busy 0; done 0. Reset wins over every other input in the same cycle.
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is registered and derived from state only, with no combinational path from in_valid. in_ready = 1 exactly in LOAD_H and LOAD_O.
- States:
  - IDLE: if start, clear index and go to LOAD_H. Banks keep their contents.
  - LOAD_H: on each transfer, write in_data to h_bias entry [index] and increment index. On the transfer at index == H_NODE_NUMBER-1, clear index and go to LOAD_O.
  - LOAD_O: on each transfer, write in_data to o_bias entry [index] and increment index. On the transfer at index == O_NODE_NUMBER-1, go to DONE.
  - DONE: if start, clear index and go to LOAD_H; done drops in the same edge.
- Latency: a written byte appears on h_bias/o_bias in the cycle after the transfer edge. The last transfer and the done assertion appear on the same following cycle.
- in_ready has no gaps within a load. A full load takes H_NODE_NUMBER+O_NODE_NUMBER transfers, i.e. 30 cycles at default parameters with valid held high.
- start while busy is ignored.
- abort:
  - In LOAD_H or LOAD_O, go to IDLE on the next edge.
  - Any transfer coinciding with abort is discarded; abort takes priority.
  - Entries already written stay written. done stays 0.
  - In IDLE or DONE, abort goes to IDLE; done drops.
- start and abort together in IDLE or DONE: abort wins, state becomes IDLE.
- in_valid with in_ready low (IDLE or DONE): data ignored, no bank change.
- Index width: clog2(max(H_NODE_NUMBER, O_NODE_NUMBER)). Index never exceeds the active bank size minus one.
- Banks are plain registers with no read port other than the flat outputs. Outputs are register-driven with no combinational logic after the flops.

Decomposition:
- Shared package bias_pkg:
  - state enum: IDLE, LOAD_H, LOAD_O, DONE
  - default node counts, DATA_WIDTH
  - index-width function
- One natural sub-module: bias_bank, a parameterised N×DATA_WIDTH register bank with ports clk, rst, we, waddr, wdata, flat data output. It is instantiated twice, once for the hidden bank and once for the output bank. The top module holds the FSM and index counter.

Test Plan:
- Reset then idle: rst high 2 cycles, then in_valid=1 with in_data=8'h55 and no start → in_ready=0; h_bias and o_bias all zero; busy=0; done=0.
- Full load: start, then stream bytes 0x01..0x1E with valid always high → in_ready high for exactly 30 cycles; h_bias byte i = i+1 for i=0..19; o_bias byte j = 0x15+j for j=0..9; done=1 the cycle after the 30th transfer.
- Backpressure gaps: same load with in_valid toggling 1,0,0,1 → same final bank contents as the full load; index advances only on transfer edges; done asserts after the 30th actual transfer.
- Abort mid-load: after 5 transfers of 0xA0..0xA4, assert abort together with in_data=0xFF and valid → next cycle IDLE; h_bias bytes 0..4 = A0..A4; byte 5 unchanged; done=0.
- Reload from DONE: after a full load of 0x01..0x1E, start again and stream 0x80..0x9D → done drops on the start edge; all entries replaced; done reasserts after the 30th transfer.
- Reset mid-operation and start/abort priority: rst during LOAD_O → banks zeroed and IDLE next cycle; in DONE, start+abort in the same cycle → IDLE, done=0, in_ready=0.
